// File: rtl/lwdo_regbus_initiator_pkg.sv
// Shared types and bus codes for the register-bus initiator: FSM states,
// access and status encodings, and sizing helpers.
package lwdo_regbus_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_RESPONSE = 2'b10
    } state_e;

    localparam logic [1:0] ACCESS_READ         = 2'b10;
    localparam logic [1:0] ACCESS_WRITE        = 2'b11;
    localparam logic [1:0] ACCESS_POSTED_WRITE = 2'b01;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY = 2'b01;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    // A disabled timeout still keeps a one-bit counter so no zero-width vectors appear.
    function automatic int unsigned counter_width(input int unsigned cycles);
        return (cycles < 32'd1) ? 32'd1 : $clog2(cycles + 32'd1);
    endfunction

    function automatic logic [1:0] access_code(input logic write);
        return write ? ACCESS_WRITE : ACCESS_READ;
    endfunction

endpackage

// File: rtl/lwdo_regbus_initiator_if.sv
// Request, register-bus and response signals of the initiator, bundled with
// a master view (the initiator) and a slave view (host + register block).
interface lwdo_regbus_initiator_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [ADDRESS_WIDTH-1:0]   req_address;
    logic [BUS_WIDTH-1:0]       req_write_data;
    logic [BUS_WIDTH/8-1:0]     req_strobe;

    logic                       register_valid;
    logic [1:0]                 register_access;
    logic [ADDRESS_WIDTH-1:0]   register_address;
    logic [BUS_WIDTH-1:0]       register_write_data;
    logic [BUS_WIDTH/8-1:0]     register_strobe;
    logic                       register_active;
    logic                       register_ready;
    logic [1:0]                 register_status;
    logic [BUS_WIDTH-1:0]       register_read_data;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [BUS_WIDTH-1:0]       rsp_read_data;
    logic [1:0]                 rsp_status;

    modport master (
        input  req_valid, req_write, req_address, req_write_data, req_strobe,
        output req_ready,
        output register_valid, register_access, register_address,
               register_write_data, register_strobe,
        input  register_active, register_ready, register_status, register_read_data,
        output rsp_valid, rsp_read_data, rsp_status,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_write, req_address, req_write_data, req_strobe,
        input  req_ready,
        input  register_valid, register_access, register_address,
               register_write_data, register_strobe,
        output register_active, register_ready, register_status, register_read_data,
        input  rsp_valid, rsp_read_data, rsp_status,
        output rsp_ready
    );
endinterface

// File: rtl/lwdo_regbus_initiator_timeout.sv
// Access watchdog: counts cycles spent waiting on the register bus and flags
// the last permitted cycle. The count saturates instead of wrapping.
module lwdo_regbus_timeout
    import lwdo_regbus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned     CNT_W     = counter_width(TIMEOUT_CYCLES);
    localparam bit              EXPIRE_EN = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [CNT_W-1:0] LAST     = EXPIRE_EN ? CNT_W'(TIMEOUT_CYCLES - 32'd1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over enable; saturate at full scale.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = EXPIRE_EN && (count_q == LAST);

endmodule

// File: rtl/lwdo_regbus_initiator.sv
// Register-bus initiator: takes one request, runs it on the register bus until
// the block answers, no register decodes, or the watchdog fires, then returns a response.
module lwdo_regbus_initiator
    import lwdo_regbus_initiator_pkg::*;
#(
    parameter int          ADDRESS_WIDTH  = 8,
    parameter int          BUS_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    lwdo_regbus_initiator_if.master bus
);
    localparam int STRB_W = BUS_WIDTH / 8;

    state_e                     state_q, state_d;
    logic                       req_ready_q, req_ready_d;
    logic                       register_valid_q, register_valid_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [1:0]                 access_q, access_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic [BUS_WIDTH-1:0]       write_data_q, write_data_d;
    logic [STRB_W-1:0]          strobe_q, strobe_d;
    logic [BUS_WIDTH-1:0]       rsp_read_data_q, rsp_read_data_d;
    logic [1:0]                 rsp_status_q, rsp_status_d;

    logic timeout_clear_s;
    logic timeout_enable_s;
    logic timeout_expired_s;

    lwdo_regbus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (timeout_clear_s),
        .i_enable  (timeout_enable_s),
        .o_expired (timeout_expired_s)
    );

    // Next state, capture and completion logic; handshake flags follow the next state.
    always_comb begin
        state_d          = state_q;
        access_d         = access_q;
        address_d        = address_q;
        write_data_d     = write_data_q;
        strobe_d         = strobe_q;
        rsp_read_data_d  = rsp_read_data_q;
        rsp_status_d     = rsp_status_q;
        timeout_clear_s  = 1'b0;
        timeout_enable_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    access_d        = access_code(bus.req_write);
                    address_d       = bus.req_address;
                    write_data_d    = bus.req_write_data;
                    strobe_d        = bus.req_write ? bus.req_strobe : {STRB_W{1'b1}};
                    timeout_clear_s = 1'b1;
                    state_d         = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A responder answer beats both the decode miss and the watchdog.
                if (bus.register_ready) begin
                    rsp_read_data_d = access_q[0] ? '0 : bus.register_read_data;
                    rsp_status_d    = bus.register_status;
                    state_d         = ST_RESPONSE;
                end else if (!bus.register_active) begin
                    rsp_read_data_d = '0;
                    rsp_status_d    = STATUS_DECERR;
                    state_d         = ST_RESPONSE;
                end else if (timeout_expired_s) begin
                    rsp_read_data_d = '0;
                    rsp_status_d    = STATUS_SLVERR;
                    state_d         = ST_RESPONSE;
                end else begin
                    timeout_enable_s = 1'b1;
                    state_d          = ST_ACCESS;
                end
            end
            ST_RESPONSE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESPONSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d      = (state_d == ST_IDLE);
        register_valid_d = (state_d == ST_ACCESS);
        rsp_valid_d      = (state_d == ST_RESPONSE);
    end

    // State register and registered handshake flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= ST_IDLE;
            req_ready_q      <= 1'b1;
            register_valid_q <= 1'b0;
            rsp_valid_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            register_valid_q <= register_valid_d;
            rsp_valid_q      <= rsp_valid_d;
        end
    end

    // Captured request and latched response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            access_q        <= 2'b00;
            address_q       <= '0;
            write_data_q    <= '0;
            strobe_q        <= '0;
            rsp_read_data_q <= '0;
            rsp_status_q    <= 2'b00;
        end else begin
            access_q        <= access_d;
            address_q       <= address_d;
            write_data_q    <= write_data_d;
            strobe_q        <= strobe_d;
            rsp_read_data_q <= rsp_read_data_d;
            rsp_status_q    <= rsp_status_d;
        end
    end

    assign bus.req_ready           = req_ready_q;
    assign bus.register_valid      = register_valid_q;
    assign bus.register_access     = access_q;
    assign bus.register_address    = address_q;
    assign bus.register_write_data = write_data_q;
    assign bus.register_strobe     = strobe_q;
    assign bus.rsp_valid           = rsp_valid_q;
    assign bus.rsp_read_data       = rsp_read_data_q;
    assign bus.rsp_status          = rsp_status_q;

endmodule

// File: tb/tb_lwdo_regbus_initiator.sv
// Directed bench for lwdo_regbus_initiator: a 4-cycle-timeout instance for the
// main traffic and a timeout-disabled instance for the endless-wait case.
module tb_lwdo_regbus_initiator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lwdo_regbus_initiator_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) a_if ();
    lwdo_regbus_initiator_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) b_if ();

    lwdo_regbus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (a_if)
    );

    lwdo_regbus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b_if)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  status;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction on instance A starting from an idle negedge.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int ready_at, input logic active,
                           input logic [1:0] st_in, input logic [31:0] rd_in,
                           input int exp_cycles, input logic [31:0] exp_data,
                           input logic [1:0] exp_status, input int stall);
        int   cyc;
        rsp_t e;
        rsp_t got;
        check("idle_req_ready", a_if.req_ready, 1);
        a_if.req_valid      = 1'b1;
        a_if.req_write      = wr;
        a_if.req_address    = addr;
        a_if.req_write_data = wdata;
        a_if.req_strobe     = strb;
        exp_q.push_back('{data: exp_data, status: exp_status});
        @(negedge clk);
        a_if.req_valid = 1'b0;
        check("valid_after_accept", a_if.register_valid, 1);
        cyc = 0;
        while (a_if.register_valid === 1'b1 && cyc < 200) begin
            check("bus_access", a_if.register_access, wr ? 2'b11 : 2'b10);
            check("bus_addr", a_if.register_address, addr);
            check("bus_wdata", a_if.register_write_data, wdata);
            check("bus_strobe", a_if.register_strobe, wr ? strb : 4'hF);
            check("busy_req_ready", a_if.req_ready, 0);
            check("busy_rsp_valid", a_if.rsp_valid, 0);
            a_if.register_ready     = (cyc == ready_at);
            a_if.register_active    = active;
            a_if.register_status    = st_in;
            a_if.register_read_data = rd_in;
            cyc++;
            @(negedge clk);
        end
        a_if.register_ready  = 1'b0;
        a_if.register_active = 1'b1;
        check("valid_cycles", cyc, exp_cycles);
        check("rsp_valid", a_if.rsp_valid, 1);
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '0;
        end
        got = '{data: a_if.rsp_read_data, status: a_if.rsp_status};
        check("rsp_data", got.data, e.data);
        check("rsp_status", got.status, e.status);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", a_if.rsp_valid, 1);
            check("stall_rsp_data", a_if.rsp_read_data, e.data);
            check("stall_rsp_status", a_if.rsp_status, e.status);
            check("stall_req_ready", a_if.req_ready, 0);
        end
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        a_if.rsp_ready = 1'b0;
        check("done_rsp_valid", a_if.rsp_valid, 0);
        check("done_req_ready", a_if.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_address = 8'h00;
        a_if.req_write_data = 32'h0; a_if.req_strobe = 4'h0;
        a_if.register_active = 1'b0; a_if.register_ready = 1'b0;
        a_if.register_status = 2'b00; a_if.register_read_data = 32'h0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_address = 8'h00;
        b_if.req_write_data = 32'h0; b_if.req_strobe = 4'h0;
        b_if.register_active = 1'b0; b_if.register_ready = 1'b0;
        b_if.register_status = 2'b00; b_if.register_read_data = 32'h0; b_if.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", a_if.req_ready, 1);
        check("rst_reg_valid", a_if.register_valid, 0);
        check("rst_access", a_if.register_access, 0);
        check("rst_addr", a_if.register_address, 0);
        check("rst_wdata", a_if.register_write_data, 0);
        check("rst_strobe", a_if.register_strobe, 0);
        check("rst_rsp_valid", a_if.rsp_valid, 0);
        check("rst_rsp_data", a_if.rsp_read_data, 0);
        check("rst_rsp_status", a_if.rsp_status, 0);
        rst = 1'b0;
        a_if.register_active = 1'b1;
        @(negedge clk);

        // wr addr wdata strobe ready_at active st_in rd_in cycles exp_data exp_st stall
        run_txn(1'b0, 8'h04, 32'h0, 4'h0, 2, 1'b1, 2'b00, 32'hDEADBEEF, 3, 32'hDEADBEEF, 2'b00, 0);
        run_txn(1'b1, 8'h08, 32'h12345678, 4'b0101, 0, 1'b1, 2'b00, 32'hFFFFFFFF, 1, 32'h0, 2'b00, 0);
        run_txn(1'b0, 8'hF0, 32'h0, 4'h0, -1, 1'b0, 2'b00, 32'h11111111, 1, 32'h0, 2'b11, 0);
        run_txn(1'b0, 8'h10, 32'h0, 4'h0, -1, 1'b1, 2'b00, 32'h22222222, 4, 32'h0, 2'b10, 0);
        run_txn(1'b0, 8'h14, 32'h0, 4'h0, 3, 1'b1, 2'b01, 32'hA5A55A5A, 4, 32'hA5A55A5A, 2'b01, 0);
        run_txn(1'b0, 8'h18, 32'h0, 4'h0, 0, 1'b0, 2'b00, 32'h0BADF00D, 1, 32'h0BADF00D, 2'b00, 0);
        run_txn(1'b1, 8'h1C, 32'hCAFEF00D, 4'hF, 1, 1'b1, 2'b10, 32'h33333333, 2, 32'h0, 2'b10, 5);

        // Reset pulse in the middle of an access.
        a_if.req_valid = 1'b1; a_if.req_write = 1'b0; a_if.req_address = 8'h30;
        @(negedge clk);
        a_if.req_valid = 1'b0;
        check("rst_mid_valid_before", a_if.register_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_reg_valid", a_if.register_valid, 0);
        check("rst_mid_req_ready", a_if.req_ready, 1);
        check("rst_mid_addr", a_if.register_address, 0);
        check("rst_mid_access", a_if.register_access, 0);
        check("rst_mid_rsp_valid", a_if.rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        n_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_if.rsp_valid !== 1'b0 || a_if.register_valid !== 1'b0) n_bad++;
        end
        check("rst_mid_no_rsp", n_bad, 0);
        check("sb_empty_after_rst", exp_q.size(), 0);
        run_txn(1'b0, 8'h20, 32'h0, 4'h0, 0, 1'b1, 2'b00, 32'h13579BDF, 1, 32'h13579BDF, 2'b00, 0);

        // Timeout disabled: the access must wait indefinitely.
        b_if.register_active = 1'b1;
        b_if.req_valid = 1'b1; b_if.req_address = 8'h40;
        @(negedge clk);
        b_if.req_valid = 1'b0;
        n_bad = 0;
        repeat (1000) begin
            if (b_if.register_valid !== 1'b1 || b_if.rsp_valid !== 1'b0) n_bad++;
            @(negedge clk);
        end
        check("notimeout_wait", n_bad, 0);
        b_if.register_ready = 1'b1;
        b_if.register_read_data = 32'h0000600D;
        @(negedge clk);
        b_if.register_ready = 1'b0;
        check("notimeout_rsp_valid", b_if.rsp_valid, 1);
        check("notimeout_rsp_status", b_if.rsp_status, 2'b00);
        check("notimeout_rsp_data", b_if.rsp_read_data, 32'h0000600D);
        b_if.rsp_ready = 1'b1;
        @(negedge clk);
        b_if.rsp_ready = 1'b0;
        check("notimeout_done", b_if.rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
